// File: rtl/store_truncate_unit.sv
// Narrowing store unit: writes a byte, half or word to a byte-wide memory, one byte per cycle, little-endian.
// Optional range check on the narrowed value is enabled by defining STORE_TRUNC_CHECK_EN.
module store_truncate_unit (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Size,
  input  logic        ExtSel,
  input  logic [31:0] Addr,
  input  logic [31:0] DataIn,
  output logic        Busy,
  output logic        Done,
  output logic        MemWr,
  output logic [31:0] MemAddr,
  output logic [7:0]  MemData,
  output logic        Misaligned,
  output logic        TruncErr,
  output logic [1:0]  state_dbg
);

  // Handshake: Start is a request sampled only in IDLE; Busy marks the unit as
  // unable to accept, and Done is a one-cycle completion pulse after the last write.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, data_q;
  logic [1:0]  size_q;
  logic        ext_q;
  logic [1:0]  cnt_q;
  logic        misaligned_q, trunc_q;
  logic        accept, reject, last_byte, trunc_calc;
  logic [1:0]  last_idx;
  logic        unused_ext;

  assign accept = (state_q == IDLE) && Start;
  assign reject = (Size == 2'b11) ||
                  ((Size == 2'b01) && Addr[0]) ||
                  ((Size == 2'b10) && (Addr[1:0] != 2'b00));

  // The sign-extension mode only matters at acceptance; the latched copy is kept for visibility.
  assign unused_ext = ext_q;

`ifdef STORE_TRUNC_CHECK_EN
  always_comb begin
    trunc_calc = 1'b0;
    case (Size)
      2'b00: trunc_calc = ExtSel ? (DataIn[31:8] != {24{DataIn[7]}}) : (|DataIn[31:8]);
      2'b01: trunc_calc = ExtSel ? (DataIn[31:16] != {16{DataIn[15]}}) : (|DataIn[31:16]);
      default: trunc_calc = 1'b0;
    endcase
  end
`else
  assign trunc_calc = 1'b0;
`endif

  always_comb begin
    last_idx = 2'd3;
    case (size_q)
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  assign last_byte = (cnt_q == last_idx);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = reject ? DONE : WRITE;
      WRITE:   if (last_byte) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      size_q       <= '0;
      ext_q        <= 1'b0;
      cnt_q        <= '0;
      misaligned_q <= 1'b0;
      trunc_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q       <= Addr;
        data_q       <= DataIn;
        size_q       <= Size;
        ext_q        <= ExtSel;
        cnt_q        <= '0;
        misaligned_q <= reject;
        trunc_q      <= !reject && trunc_calc;
      end else if (state_q == WRITE) begin
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

  // Memory outputs are forced to zero outside WRITE so idle bus cycles are clean.
  assign MemWr      = (state_q == WRITE);
  assign MemAddr    = MemWr ? (addr_q + 32'(cnt_q)) : 32'd0;
  assign MemData    = MemWr ? data_q[{cnt_q, 3'b000} +: 8] : 8'd0;
  assign Busy       = (state_q == WRITE) || (state_q == DONE);
  assign Done       = (state_q == DONE);
  assign Misaligned = misaligned_q;
  assign TruncErr   = trunc_q;
  assign state_dbg  = state_q;

endmodule

// File: doc/store_truncate_unit.md
STORE_TRUNCATE_UNIT -- requirements
Module: store_truncate_unit

Interface
REQ-001 The module SHALL have the port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The module SHALL have the port Reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-003 The module SHALL have the port Start, input, 1 bit: store request, sampled only in IDLE.
REQ-004 The module SHALL have the port Size, input, 2 bits: 00 byte, 01 half, 10 word, 11 reserved.
REQ-005 The module SHALL have the port ExtSel, input, 1 bit: 1 = signed range check, 0 = unsigned range check.
REQ-006 The module SHALL have the port Addr, input, 32 bits: byte address of the store.
REQ-007 The module SHALL have the port DataIn, input, 32 bits: register value to narrow and store.
REQ-008 The module SHALL have the port Busy, output, 1 bit: high in WRITE and DONE.
REQ-009 The module SHALL have the port Done, output, 1 bit: one-cycle completion pulse.
REQ-010 The module SHALL have the port MemWr, output, 1 bit: byte-memory write strobe.
REQ-011 The module SHALL have the port MemAddr, output, 32 bits: byte-memory address.
REQ-012 The module SHALL have the port MemData, output, 8 bits: byte-memory write data.
REQ-013 The module SHALL have the port Misaligned, output, 1 bit: request rejected; held until the next accepted Start.
REQ-014 The module SHALL have the port TruncErr, output, 1 bit: narrowing lost information; held until the next accepted Start.

Function
REQ-015 The module SHALL implement the states IDLE, WRITE and DONE.
REQ-016 IDLE with Start=1 SHALL latch Addr, DataIn, Size and ExtSel, clear Misaligned and TruncErr, and then take one of two paths:
- valid request -> WRITE, with the byte counter set to 0;
- rejected request -> DONE, with Misaligned set to 1.
REQ-017 A request SHALL be rejected when any of the following holds:
- Size=11;
- Size=01 and Addr[0]=1;
- Size=10 and Addr[1:0]!=00.
REQ-018 A rejected request SHALL produce no MemWr pulse.
REQ-019 Each WRITE cycle k (k = 0..N-1, with N = 1/2/4 for byte/half/word) SHALL drive:
- MemWr=1;
- MemAddr = latched Addr + k, modulo 2^32;
- MemData = latched DataIn[8k+7:8k] (little-endian order).
REQ-020 WRITE SHALL go to DONE after cycle N-1.
REQ-021 DONE SHALL assert Done=1 for exactly one cycle and then return to IDLE.
REQ-022 Latency SHALL be as follows, counting the Start edge as cycle 0:
- MemWr is high in cycles 1..N;
- Done is high in cycle N+1;
- a new Start is accepted in cycle N+2 at the earliest;
- for a rejected request, Done is high in cycle 1.
REQ-023 Start SHALL be ignored while Busy=1, including in the DONE cycle; latched values SHALL NOT change while Busy=1.
REQ-024 In any cycle where MemWr=0, MemWr, MemAddr and MemData SHALL all be 0.
REQ-025 TruncErr SHALL be computed at Start acceptance from DataIn as follows:
- byte: the upper 24 bits are not all equal to bit 7 (ExtSel=1), or are not all zero (ExtSel=0);
- half: the upper 16 bits are not all equal to bit 15 (ExtSel=1), or are not all zero (ExtSel=0);
- word: TruncErr is never set.
REQ-026 TruncErr=1 SHALL NOT suppress the writes; the truncated bytes SHALL still be stored.
REQ-027 For a rejected request, TruncErr SHALL stay 0.

Reset
REQ-028 Reset=0 SHALL immediately, without waiting for a clock edge, force the following:
- state = IDLE;
- Busy, Done, MemWr, Misaligned and TruncErr = 0;
- MemAddr = 0 and MemData = 0;
- byte counter = 0.
REQ-029 Reset asserted mid-WRITE SHALL abandon the remaining bytes and produce no Done.
REQ-030 After Reset releases, the first rising edge with Start=1 SHALL be accepted normally.

Configuration
REQ-031 When the macro STORE_TRUNC_CHECK_EN is defined, TruncErr SHALL behave as specified in REQ-025 to REQ-027.
REQ-032 When STORE_TRUNC_CHECK_EN is not defined, the range-check logic SHALL be omitted and TruncErr SHALL be constant 0; all other behaviour SHALL be unchanged.

Verification
REQ-033 Byte store: Size=00, Addr=0x00000103, DataIn=0xFFFFFF80, ExtSel=1 -> a single MemWr to 0x103 with data 0x80; Done in cycle 2; TruncErr=0.
REQ-034 Word store: Size=10, Addr=0x10, DataIn=0x12345678 -> writes 0x10/0x78, 0x11/0x56, 0x12/0x34, 0x13/0x12 in cycles 1-4; Done in cycle 5; Busy high in cycles 1-5.
REQ-035 Truncation (macro defined): Size=01, Addr=0x20, DataIn=0x00018000, ExtSel=0 -> TruncErr=1; writes 0x20/0x00 and 0x21/0x80 still occur. Repeat with DataIn=0xFFFF8000, ExtSel=1 -> TruncErr=0.
REQ-036 Misalignment and wrap-around, as three cases:
- Size=10, Addr=0x22 -> no MemWr; Done in cycle 1; Misaligned=1.
- Size=11 -> same response as the misaligned word store.
- Size=01, Addr=0xFFFFFFFE -> writes to 0xFFFFFFFE and 0xFFFFFFFF.
REQ-037 Busy and reset: Start pulsed again in cycles 2 and 5 of a word store -> both pulses ignored. Reset=0 during cycle 2 of a word store -> MemWr drops at once, no Done; a Start after release completes normally.
